// File: rtl/secret_rotate_buffer.sv
// Secret-polynomial buffer: loads packed two's-complement coefficients, stores them
// in sign-magnitude form and rotates them negacyclically, one position per step.
module secret_rotate_buffer #(
   parameter int N = 256,
   parameter int W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 load_valid,
   input  logic [W-1:0]         load_data,
   output logic                 load_ready,
   input  logic                 shift_en,
   output logic                 ready,
   output logic                 done,
   output logic [$clog2(N)-1:0] shift_cnt,
   output logic                 err,
   output logic [4*N-1:0]       s_bus
);

   localparam int CPW   = W / 4;
   localparam int WORDS = N / CPW;
   localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CW    = $clog2(N);
   localparam int CPWB  = $clog2(CPW);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t                state_reg;
   logic [WCW-1:0]        word_cnt_reg;
   logic [N-1:0][3:0]     s_reg;
   logic [CPW-1:0][4:0]   conv;
   logic [CPW-1:0]        conv_bad;
   logic [CW-1:0]         base;

   // Returns {out_of_range, sign, mag[2:0]}; out-of-range values store as +0.
   function automatic logic [4:0] convert(input logic [3:0] nib);
      logic signed [3:0] v;
      logic signed [3:0] m;
      v = $signed(nib);
      m = -v;
      if (v >= 0 && v <= 5)
         return {2'b00, nib[2:0]};
      else if (v < 0 && v >= -5)
         return {2'b01, m[2:0]};
      else
         return 5'b10000;
   endfunction

   // Negation of a sign-magnitude coefficient never produces -0.
   function automatic logic [3:0] neg(input logic [3:0] c);
      return {c[3] ^ (|c[2:0]), c[2:0]};
   endfunction

   generate
      for (genvar gi = 0; gi < CPW; gi++) begin : g_conv
         assign conv[gi]     = convert(load_data[4*gi +: 4]);
         assign conv_bad[gi] = conv[gi][4];
      end
   endgenerate

   assign base  = CW'({word_cnt_reg, {CPWB{1'b0}}});
   assign s_bus = s_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_reg <= '0;
      end else if (load_ready && load_valid) begin
         for (int i = 0; i < CPW; i++)
            s_reg[base + CW'(i)] <= conv[i][3:0];
      end else if (ready && shift_en) begin
         s_reg <= {s_reg[N-2:0], neg(s_reg[N-1])};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         word_cnt_reg <= '0;
         shift_cnt    <= '0;
         err          <= 1'b0;
         done         <= 1'b0;
         ready        <= 1'b0;
         load_ready   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg    <= LOAD;
                  load_ready   <= 1'b1;
                  word_cnt_reg <= '0;
                  shift_cnt    <= '0;
                  err          <= 1'b0;
               end
            end
            LOAD: begin
               if (load_valid) begin
                  err          <= err | (|conv_bad);
                  word_cnt_reg <= word_cnt_reg + 1'b1;
                  if (word_cnt_reg == WCW'(WORDS - 1)) begin
                     state_reg  <= RUN;
                     load_ready <= 1'b0;
                     ready      <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (shift_en) begin
                  shift_cnt <= shift_cnt + 1'b1;
                  if (shift_cnt == CW'(N - 1)) begin
                     state_reg <= IDLE;
                     done      <= 1'b1;
                     ready     <= 1'b0;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/secret_rotate_buffer.md
# secret_rotate_buffer

Holds the full secret polynomial for one polynomial multiplication and presents every coefficient, in parallel and in sign-magnitude form, to the array of small multiply-accumulate ALUs. It sits directly upstream of those ALUs, which take a 4-bit operand: bit 3 is the sign and bits 2:0 are the magnitude (0..5). The block loads packed two's-complement coefficients from data memory, converts them, and rotates the polynomial negacyclically, one position per step. While it rotates, the public coefficients are broadcast to the ALUs.

## Interface
- N, 256: polynomial length; coefficient count held.
- W, 64: memory word width; W/4 coefficients per word; N*4/W words per load (16 at default).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a new load; honoured only in IDLE.
- load_valid  in  1  load_data holds a word.
- load_data  in  W  packed coefficients; coefficient j at bits [4j+3:4j], 4-bit two's complement.
- load_ready  out  1  high in LOAD; a word is accepted when load_valid && load_ready.
- shift_en  in  1  request one negacyclic rotation; honoured only in RUN.
- ready  out  1  high in RUN (buffer loaded, rotation allowed).
- done  out  1  one-cycle pulse on the N-th accepted rotation.
- shift_cnt  out  log2(N)  rotations performed since the load.
- err  out  1  sticky out-of-range flag; cleared by rst or start.
- s_bus  out  4N  coefficient i at [4i+3:4i], as {sign, mag[2:0]}.

## Operation
- States:
  - IDLE: start goes to LOAD; clears the word counter, shift_cnt and err.
  - LOAD: accepts words.
  - RUN: accepts rotations.
- Load:
  - Accepted word k (0..N*4/W-1) writes coefficients kW/4 .. kW/4+W/4-1.
  - After the last word is accepted, the state moves to RUN.
  - Words arriving while load_valid is low are simply waited for; there is no timeout.
- Conversion of each 4-bit value v:
  - v in 0..5 gives {0, v}.
  - v in -5..-1 gives {1, -v}.
  - Any other value (6, 7, -8..-6) stores 4'b0000 and sets err.
  - The result is never "-0": magnitude 0 always has sign 0.
- Rotation, on shift_en in RUN:
  - s'[i] = s[i-1] for i = 1..N-1.
  - s'[0] = neg(s[N-1]), where neg flips the sign bit only when the magnitude is nonzero.
  - shift_cnt increments, wrapping to 0.
- End of run:
  - When shift_en is accepted with shift_cnt == N-1, done pulses and the state moves to IDLE.
  - At that point every coefficient equals the negation of its loaded value.
  - s_bus holds that value until the next load overwrites it.
- Ignored inputs: shift_en outside RUN; start outside IDLE; load_valid outside LOAD.
- Reset, from any state including mid-load or mid-run:
  - Next cycle: IDLE, with s_bus, shift_cnt, err, done, ready and load_ready all 0.
  - No partial data survives.

## Timing
- All outputs are registered. Every output resets to 0.
- load_ready rises the cycle after start is sampled in IDLE.
- A word accepted at edge t appears on s_bus after edge t.
- ready rises, and load_ready falls, the cycle after the last word is accepted.
- shift_en sampled at edge t gives the rotated s_bus, incremented shift_cnt and (if applicable) done after edge t.
- Throughput is one rotation per cycle. shift_en may be held high for N back-to-back cycles.
- done is high for exactly one cycle. ready falls in the same cycle done is high.
- start asserted in the same cycle as done's triggering shift_en is ignored, because the state is still RUN. Asserted in the cycle after done, it is accepted.

## Test plan
- Load 16 words, each coefficient j = (j mod 11) − 5 → s_bus[3:0] = 4'b1101 (−5), s_bus[23:20] = 4'b0000, s_bus[43:40] = 4'b0101 (+5); ready = 1, err = 0.
- Load with s[N−1] = +3 (4'b0011) and s[0] = −2, then one shift_en → s'[0] = 4'b1011, s'[1] = 4'b1010, shift_cnt = 1.
- Wrapped coefficient with value 0: s[N−1] = 0, one shift → s'[0] = 4'b0000, never 4'b1000.
- Load random in-range values, then N consecutive shifts → done is a single pulse on the 256th, shift_cnt = 0, every coefficient is the negation of its loaded value, state IDLE.
- Word containing nibbles 4'h6, 4'h8 and 4'hA → those coefficients are 0 and err = 1 and stays set until the next start; nibble 4'hB (−5) converts to 4'b1101.
- Assert rst after 7 words, and separately after 100 shifts; also drive shift_en in IDLE/LOAD and start in RUN → after reset, all outputs are 0 and the state is IDLE; the ignored inputs change nothing.
